// File: rtl/router_local_inport.sv
// rtl/router_local_inport.sv - Local PE input port: FWFT flit buffer, credit return, packet framing tracker.
// Optional overflow detector enabled by defining ROUTER_INPORT_OVF_CHECK_EN (adds ovf_err output).
module router_local_inport #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          RST,
    input  logic [19:0]   datain,
    input  logic          in_valid,
    output logic          co,
    output logic [19:0]   dataout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          head_flit,
    output logic          pkt_active,
    output logic [CW-1:0] count,
    output logic          proto_err
`ifdef ROUTER_INPORT_OVF_CHECK_EN
    ,
    output logic          ovf_err
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    logic [19:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_co;
    logic          r_proto_err;
    state_t        r_state;

    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic [1:0]    w_type;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = ~w_empty & out_ready;
    assign w_push  = in_valid & (~w_full | w_pop);
    assign w_type  = r_mem[r_rd_ptr][19:18];

    assign dataout    = r_mem[r_rd_ptr];
    assign out_valid  = ~w_empty;
    assign count      = r_count;
    assign co         = r_co;
    assign proto_err  = r_proto_err;
    assign pkt_active = (r_state == S_BUSY);
    assign head_flit  = ~w_empty & (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= datain;
        end
    end

    always_ff @(posedge clk) begin
        if (!RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_co     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_co <= w_pop;
        end
    end

    // Framing advances only when a flit actually leaves toward the switch.
    always_ff @(posedge clk) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            r_proto_err <= 1'b0;
        end else if (w_pop) begin
            case (r_state)
                S_IDLE: begin
                    case (w_type)
                        T_HEAD:   r_state <= S_BUSY;
                        T_SINGLE: r_state <= S_IDLE;
                        default:  r_proto_err <= 1'b1;
                    endcase
                end
                S_BUSY: begin
                    case (w_type)
                        T_BODY:  r_state <= S_BUSY;
                        T_TAIL:  r_state <= S_IDLE;
                        T_HEAD:  r_proto_err <= 1'b1;
                        default: begin
                            r_proto_err <= 1'b1;
                            r_state     <= S_IDLE;
                        end
                    endcase
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ROUTER_INPORT_OVF_CHECK_EN
    logic r_ovf_err;
    logic w_ovf;

    assign w_ovf   = in_valid & w_full & ~w_pop;
    assign ovf_err = r_ovf_err;

    always_ff @(posedge clk) begin
        if (!RST) begin
            r_ovf_err <= 1'b0;
        end else if (w_ovf) begin
            r_ovf_err <= 1'b1;
`ifndef SYNTHESIS
            $error("router_local_inport: flit pushed while buffer full, dropped");
`endif
        end
    end
`endif

endmodule

// File: tb/tb_router_local_inport.sv
// tb/tb_router_local_inport.sv - Directed plus random checking of router_local_inport against a queue model.
module tb_router_local_inport;

    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic          clk;
    logic          RST;
    logic [19:0]   datain;
    logic          in_valid;
    logic          co;
    logic [19:0]   dataout;
    logic          out_valid;
    logic          out_ready;
    logic          head_flit;
    logic          pkt_active;
    logic [CW-1:0] count;
    logic          proto_err;
`ifdef ROUTER_INPORT_OVF_CHECK_EN
    logic          ovf_err;
`endif

    router_local_inport #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk        (clk),
        .RST        (RST),
        .datain     (datain),
        .in_valid   (in_valid),
        .co         (co),
        .dataout    (dataout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .head_flit  (head_flit),
        .pkt_active (pkt_active),
        .count      (count),
        .proto_err  (proto_err)
`ifdef ROUTER_INPORT_OVF_CHECK_EN
        ,
        .ovf_err    (ovf_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [19:0] m_q[$];
    bit          m_open;
    bit          m_perr;
    bit          m_co;
    bit          m_ovf;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: a packet is open between an accepted head and its tail.
    task automatic model_step(input bit rst_n, input bit vld, input logic [19:0] d, input bit rdy);
        bit          pop;
        bit          push;
        logic [19:0] f;
        if (!rst_n) begin
            m_q.delete();
            m_open = 0;
            m_perr = 0;
            m_co   = 0;
            m_ovf  = 0;
            return;
        end
        pop  = (m_q.size() > 0) && rdy;
        push = vld && ((m_q.size() < DEPTH) || pop);
        if (vld && !push) m_ovf = 1;
        m_co = pop;
        if (pop) begin
            f = m_q.pop_front();
            if (f[19:18] == 2'b01) begin
                if (m_open) m_perr = 1;
                m_open = 1;
            end else if (f[19:18] == 2'b10) begin
                if (!m_open) m_perr = 1;
                m_open = 0;
            end else if (f[19:18] == 2'b00) begin
                if (!m_open) m_perr = 1;
            end else begin
                if (m_open) m_perr = 1;
                m_open = 0;
            end
        end
        if (push) m_q.push_back(d);
    endtask

    task automatic check_all();
        check_eq("count", 32'(count), 32'(m_q.size()));
        check_eq("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        check_eq("co", 32'(co), 32'(m_co));
        check_eq("head_flit", 32'(head_flit), 32'((m_q.size() != 0) && !m_open));
        check_eq("pkt_active", 32'(pkt_active), 32'(m_open));
        check_eq("proto_err", 32'(proto_err), 32'(m_perr));
        if (m_q.size() != 0) check_eq("dataout", 32'(dataout), 32'(m_q[0]));
`ifdef ROUTER_INPORT_OVF_CHECK_EN
        check_eq("ovf_err", 32'(ovf_err), 32'(m_ovf));
`endif
    endtask

    task automatic cycle(input bit rst_n, input bit vld, input logic [19:0] d, input bit rdy);
        RST       = rst_n;
        in_valid  = vld;
        datain    = d;
        out_ready = rdy;
        model_step(rst_n, vld, d, rdy);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [31:0] rnd;
        logic [19:0] d;
        RST = 1'b0; in_valid = 1'b0; datain = '0; out_ready = 1'b0;

        cycle(0, 0, 20'h0, 0);
        cycle(0, 0, 20'h0, 0);
        cycle(1, 0, 20'h0, 0);

        // Single-flit packet, then drain it
        cycle(1, 1, 20'h30001, 0);
        check_eq("single_dataout", 32'(dataout), 32'h30001);
        cycle(1, 0, 20'h0, 1);
        cycle(1, 0, 20'h0, 0);

        // Fill with head/body/body/tail, then drain
        cycle(1, 1, 20'h1_0011, 0);
        cycle(1, 1, 20'h0_0022, 0);
        cycle(1, 1, 20'h0_0033, 0);
        cycle(1, 1, 20'h2_0044, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 20'h0, 1);
        cycle(1, 0, 20'h0, 0);

        // Full with simultaneous push/pop, then overflow attempt
        cycle(1, 1, 20'h1_0101, 0);
        cycle(1, 1, 20'h0_0102, 0);
        cycle(1, 1, 20'h0_0103, 0);
        cycle(1, 1, 20'h0_0104, 0);
        cycle(1, 1, 20'h2_0105, 1);
        cycle(1, 1, 20'h3_0bad, 0);
        cycle(1, 0, 20'h0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 20'h0, 1);

        // Framing error, then reset mid-packet with flits buffered
        cycle(1, 1, 20'h0_1234, 0);
        cycle(1, 0, 20'h0, 1);
        cycle(1, 1, 20'h1_0aaa, 0);
        cycle(1, 1, 20'h0_0bbb, 0);
        cycle(1, 1, 20'h0_0ccc, 1);
        cycle(0, 0, 20'h0, 0);
        cycle(1, 0, 20'h0, 0);

        for (int i = 0; i < 3000; i++) begin
            rnd = $urandom;
            d   = rnd[19:0];
            cycle(($urandom_range(0, 99) != 0), ($urandom_range(0, 2) != 0), d, ($urandom_range(0, 1) == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
